// File: rtl/bf16_pkg.sv
// -----------------------------------------------------------------------------
// bf16_pkg
// Shared bfloat16 types, field widths and helpers for the pair packer.
//   bf16_t              16-bit bfloat16 word {sign, exp[7:0], mant[6:0]}
//   pack_state_t        packer state: FILL (accepting) / HOLD (fill parked)
//   bf16_is_subnormal   1 when exp==0 and mant!=0
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
package bf16_pkg;

  localparam int BF16_EXP_W = 8;
  localparam int BF16_MAN_W = 7;

  typedef logic [15:0] bf16_t;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } pack_state_t;

  function automatic logic bf16_is_subnormal(input bf16_t v);
    logic exp_zero;
    logic man_nonzero;
    exp_zero    = (v[BF16_MAN_W +: BF16_EXP_W] == {BF16_EXP_W{1'b0}});
    man_nonzero = (v[BF16_MAN_W-1:0] != {BF16_MAN_W{1'b0}});
    return exp_zero & man_nonzero;
  endfunction

endpackage

// File: rtl/bf16_ftz.sv
// -----------------------------------------------------------------------------
// bf16_ftz
// Combinational flush-to-zero for one bf16 operand.
// Build option: BF16_PACK_FTZ_EN
//   defined   : subnormal input -> signed zero {sign, 15'h0}
//   undefined : wire-through (NaN, Inf and subnormals pass bit-exact)
// Ports:
//   d  in   bf16_t  operand as accepted
//   q  out  bf16_t  operand as packed
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module bf16_ftz
  import bf16_pkg::*;
(
  input  bf16_t d,
  output bf16_t q
);

  // Per-operand flush (or pass-through when the flush option is not built in)
  always_comb begin
`ifdef BF16_PACK_FTZ_EN
    if (bf16_is_subnormal(d)) begin
      q = {d[15], 15'h0000};
    end else begin
      q = d;
    end
`else
    q = d;
`endif
  end

endmodule

// File: rtl/bf16_pair_packer.sv
// -----------------------------------------------------------------------------
// bf16_pair_packer
// Packs a valid/ready stream of bf16 operand pairs into N-lane vectors for the
// bf16 comparator array. A fill buffer plus an output register give two-deep
// buffering, so one pair per clock is sustained while out_ready stays high.
// Build option: BF16_PACK_FTZ_EN (flush subnormal operands to signed zero).
// Parameters:
//   N      lanes per vector (>=1)
//   CNT_W  width of the handoff counter
// Ports:
//   clk1       in   clock, rising edge
//   rst1_n     in   asynchronous active-low reset
//   in_valid   in   in_a/in_b/in_last valid
//   in_ready   out  packer accepts this cycle (registered, low while HOLD)
//   in_a/in_b  in   bf16 operands
//   in_last    in   close the current vector after this element
//   out_valid  out  out_* hold a complete vector
//   out_ready  in   consumer takes the vector on out_valid&out_ready
//   out_a/b    out  lane i = bits [16i+15:16i], lane 0 = first accepted
//   out_mask   out  1 = real data in lane, 0 = zero padding
//   out_last   out  vector was closed by in_last
//   vec_count  out  number of handoffs, wrapping
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module bf16_pair_packer
  import bf16_pkg::*;
#(
  parameter int N     = 2,
  parameter int CNT_W = 16
) (
  input  logic              clk1,
  input  logic              rst1_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       in_a,
  input  logic [15:0]       in_b,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [16*N-1:0]   out_a,
  output logic [16*N-1:0]   out_b,
  output logic [N-1:0]      out_mask,
  output logic              out_last,
  output logic [CNT_W-1:0]  vec_count
);

  localparam int                IDX_W    = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N - 1);

  pack_state_t        state_r;
  logic               in_ready_r;
  logic [16*N-1:0]    fill_a_r;
  logic [16*N-1:0]    fill_b_r;
  logic [N-1:0]       fill_mask_r;
  logic [IDX_W-1:0]   fill_idx_r;
  logic               fill_last_r;
  logic               out_valid_r;
  logic [16*N-1:0]    out_a_r;
  logic [16*N-1:0]    out_b_r;
  logic [N-1:0]       out_mask_r;
  logic               out_last_r;
  logic [CNT_W-1:0]   vec_count_r;

  bf16_t              ftz_a_s;
  bf16_t              ftz_b_s;
  logic [16*N-1:0]    merge_a_s;
  logic [16*N-1:0]    merge_b_s;
  logic [N-1:0]       merge_mask_s;
  logic               accept_s;
  logic               close_s;
  logic               out_free_s;
  logic               handoff_s;

  bf16_ftz u_ftz_a (.d(in_a), .q(ftz_a_s));
  bf16_ftz u_ftz_b (.d(in_b), .q(ftz_b_s));

  // in_ready_r is only high in FILL, so an accept always happens in FILL
  assign accept_s   = in_valid & in_ready_r;
  assign close_s    = accept_s & ((fill_idx_r == LAST_IDX) | in_last);
  assign out_free_s = ~out_valid_r | out_ready;
  assign handoff_s  = out_valid_r & out_ready;

  // Fill buffer with the incoming element dropped into lane fill_idx; this is
  // what gets registered when the element closes the vector
  always_comb begin
    merge_a_s    = fill_a_r;
    merge_b_s    = fill_b_r;
    merge_mask_s = fill_mask_r;
    for (int i = 0; i < N; i++) begin
      merge_a_s[16*i +: 16] = (fill_idx_r == IDX_W'(i)) ? ftz_a_s : fill_a_r[16*i +: 16];
      merge_b_s[16*i +: 16] = (fill_idx_r == IDX_W'(i)) ? ftz_b_s : fill_b_r[16*i +: 16];
      merge_mask_s[i]       = (fill_idx_r == IDX_W'(i)) ? 1'b1    : fill_mask_r[i];
    end
  end

  // Packing FSM: fill buffer, output register and in_ready
  always_ff @(posedge clk1 or negedge rst1_n) begin
    if (!rst1_n) begin
      state_r     <= FILL;
      in_ready_r  <= 1'b1;
      fill_a_r    <= {(16*N){1'b0}};
      fill_b_r    <= {(16*N){1'b0}};
      fill_mask_r <= {N{1'b0}};
      fill_idx_r  <= {IDX_W{1'b0}};
      fill_last_r <= 1'b0;
      out_valid_r <= 1'b0;
      out_a_r     <= {(16*N){1'b0}};
      out_b_r     <= {(16*N){1'b0}};
      out_mask_r  <= {N{1'b0}};
      out_last_r  <= 1'b0;
    end else begin
      case (state_r)
        FILL: begin
          if (close_s && out_free_s) begin
            // Closing element goes straight to the output with the rest
            out_a_r     <= merge_a_s;
            out_b_r     <= merge_b_s;
            out_mask_r  <= merge_mask_s;
            out_last_r  <= in_last;
            out_valid_r <= 1'b1;
            fill_a_r    <= {(16*N){1'b0}};
            fill_b_r    <= {(16*N){1'b0}};
            fill_mask_r <= {N{1'b0}};
            fill_idx_r  <= {IDX_W{1'b0}};
            fill_last_r <= 1'b0;
          end else if (close_s) begin
            // Output still occupied: park the complete vector in the fill
            fill_a_r    <= merge_a_s;
            fill_b_r    <= merge_b_s;
            fill_mask_r <= merge_mask_s;
            fill_last_r <= in_last;
            state_r     <= HOLD;
            in_ready_r  <= 1'b0;
          end else if (accept_s) begin
            fill_a_r    <= merge_a_s;
            fill_b_r    <= merge_b_s;
            fill_mask_r <= merge_mask_s;
            fill_idx_r  <= fill_idx_r + IDX_W'(1);
            if (handoff_s) begin
              out_valid_r <= 1'b0;
            end else begin
              out_valid_r <= out_valid_r;
            end
          end else if (handoff_s) begin
            out_valid_r <= 1'b0;
          end else begin
            out_valid_r <= out_valid_r;
          end
        end
        HOLD: begin
          // out_free here means the consumer is taking the current vector
          if (out_free_s) begin
            out_a_r     <= fill_a_r;
            out_b_r     <= fill_b_r;
            out_mask_r  <= fill_mask_r;
            out_last_r  <= fill_last_r;
            out_valid_r <= 1'b1;
            fill_a_r    <= {(16*N){1'b0}};
            fill_b_r    <= {(16*N){1'b0}};
            fill_mask_r <= {N{1'b0}};
            fill_idx_r  <= {IDX_W{1'b0}};
            fill_last_r <= 1'b0;
            state_r     <= FILL;
            in_ready_r  <= 1'b1;
          end else begin
            state_r <= HOLD;
          end
        end
        default: begin
          state_r    <= FILL;
          in_ready_r <= 1'b1;
        end
      endcase
    end
  end

  // Handoff counter, wraps naturally at 2^CNT_W
  always_ff @(posedge clk1 or negedge rst1_n) begin
    if (!rst1_n) begin
      vec_count_r <= {CNT_W{1'b0}};
    end else if (handoff_s) begin
      vec_count_r <= vec_count_r + CNT_W'(1);
    end else begin
      vec_count_r <= vec_count_r;
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_a     = out_a_r;
  assign out_b     = out_b_r;
  assign out_mask  = out_mask_r;
  assign out_last  = out_last_r;
  assign vec_count = vec_count_r;

endmodule
